// File: rtl/tva_pkg.sv
// Shared types and helpers for the sequential A x V attention engine.
package tva_pkg;

   // Precision codes carried per key token. 16 does not fit the 4-bit code
   // field and wraps to 4'd0. Any code other than PREC_8 or PREC_4 leaves V
   // unmasked, so the wrapped value still means full precision.
   localparam logic [3:0] PREC_FULL = 4'(16);
   localparam logic [3:0] PREC_8    = 4'd8;
   localparam logic [3:0] PREC_4    = 4'd4;

   // Default number of fractional bits for A, V and Z.
   localparam int FRAC_DEF = 8;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      MAC,
      WRITE,
      DONE,
      WAIT_LOW
   } av_state_t;

   // Saturation result: the clamped value, sign-extended to 64 bits, and a
   // flag set when clamping took place.
   typedef struct packed {
      logic               ovf;
      logic signed [63:0] val;
   } sat_res_t;

   // Clamp an already-shifted accumulator value to the signed range of a
   // dw-bit word.
   function automatic sat_res_t sat_fx(input logic signed [63:0] x,
                                       input int unsigned        dw);
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      sat_res_t           r;
      hi    = (64'sd1 <<< (dw - 1)) - 64'sd1;
      lo    = -hi - 64'sd1;
      r.ovf = 1'b0;
      r.val = x;
      if (x > hi) begin
         r.val = hi;
         r.ovf = 1'b1;
      end else if (x < lo) begin
         r.val = lo;
         r.ovf = 1'b1;
      end
      return r;
   endfunction

endpackage

// File: rtl/av_mac_unit.sv
// Single-MAC datapath. It applies the precision mask to V, forms the signed
// product A*V and accumulates the product into a registered sum.
module av_mac_unit
   import tva_pkg::*;
#(
   parameter int DW    = 16,
   parameter int ACC_W = 35
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    clr,
   input  logic                    en,
   input  logic signed [DW-1:0]    a,
   input  logic signed [DW-1:0]    v,
   input  logic        [3:0]       prec,
   output logic signed [ACC_W-1:0] acc
);

   logic signed [DW-1:0]    v_m;
   logic signed [2*DW-1:0]  prod;
   logic signed [ACC_W-1:0] acc_d;
   logic signed [ACC_W-1:0] acc_q;

   // Zero the low bits of V according to the key token's precision code.
   always_comb begin
      // NOTE: give every always_comb output a default first so that no path
      // leaves it unassigned, which would infer a latch.
      v_m = v;
      if (prec == PREC_8) begin
         v_m = {v[DW-1 -: 8], {(DW-8){1'b0}}};
      end else if (prec == PREC_4) begin
         v_m = {v[DW-1 -: 4], {(DW-4){1'b0}}};
      end
   end

   assign prod = a * v_m;

   // Next accumulator value. Clear takes priority over accumulate.
   always_comb begin
      acc_d = acc_q;
      if (clr) begin
         acc_d = '0;
      end else if (en) begin
         acc_d = acc_q + ACC_W'(prod);
      end
   end

   // Accumulator register.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: sequential state uses non-blocking assignments (<=) so every
      // flop samples values from before the clock edge.
      if (!rst_n) begin
         acc_q <= '0;
      end else begin
         acc_q <= acc_d;
      end
   end

   assign acc = acc_q;

endmodule

// File: rtl/av_seq_engine.sv
// Sequential A x V attention engine: Z[l][n][e] = sum_j A[l][n][j] * Vm[j][n][e].
// The engine performs one MAC per cycle and answers the level start/done
// handshake.
module av_seq_engine
   import tva_pkg::*;
#(
   parameter int DATA_WIDTH = 16,
   parameter int FRAC       = FRAC_DEF,
   parameter int L          = 8,
   parameter int N          = 1,
   parameter int E          = 8
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           start,
   input  logic [DATA_WIDTH*L*N*L-1:0]    A_in,
   input  logic [DATA_WIDTH*L*N*E-1:0]    V_in,
   input  logic [3:0]                     token_precision [0:L-1],
   output logic [DATA_WIDTH*L*N*E-1:0]    Z_out,
   output logic                           out_valid,
   output logic                           done,
   output logic                           busy,
   output logic                           sat_flag
);

   localparam int DW    = DATA_WIDTH;
   localparam int ACC_W = 2*DW + $clog2(L);
   localparam int JW    = (L > 1) ? $clog2(L) : 1;
   localparam int EW    = (E > 1) ? $clog2(E) : 1;
   localparam int NW    = (N > 1) ? $clog2(N) : 1;

   av_state_t state_q, state_d;
   logic [JW-1:0] j_q, j_d, l_q, l_d;
   logic [EW-1:0] e_q, e_d;
   logic [NW-1:0] n_q, n_d;
   logic          sat_q, sat_d;

   logic signed [DW-1:0] a_q [L][N][L];
   logic signed [DW-1:0] a_d [L][N][L];
   logic signed [DW-1:0] v_q [L][N][E];
   logic signed [DW-1:0] v_d [L][N][E];
   logic        [3:0]    prec_q [L];
   logic        [3:0]    prec_d [L];
   logic        [DW-1:0] z_q [L][N][E];
   logic        [DW-1:0] z_d [L][N][E];

   logic                    mac_clr, mac_en;
   logic signed [ACC_W-1:0] acc;
   logic signed [63:0]      acc_shr;
   sat_res_t                sat_res;
   logic                    last_elem;

   av_mac_unit #(.DW(DW), .ACC_W(ACC_W)) u_mac (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (mac_clr),
      .en    (mac_en),
      .a     (a_q[l_q][n_q][j_q]),
      .v     (v_q[j_q][n_q][e_q]),
      .prec  (prec_q[j_q]),
      .acc   (acc)
   );

   assign last_elem = (e_q == EW'(E-1)) && (l_q == JW'(L-1)) && (n_q == NW'(N-1));

   // FSM next state, counter advance and handshake outputs.
   always_comb begin
      state_d   = state_q;
      j_d       = j_q;
      e_d       = e_q;
      l_d       = l_q;
      n_d       = n_q;
      mac_clr   = 1'b0;
      mac_en    = 1'b0;
      busy      = 1'b0;
      done      = 1'b0;
      out_valid = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) state_d = LOAD;
         end
         LOAD: begin
            busy    = 1'b1;
            mac_clr = 1'b1;
            j_d     = '0;
            e_d     = '0;
            l_d     = '0;
            n_d     = '0;
            state_d = MAC;
         end
         MAC: begin
            busy   = 1'b1;
            mac_en = 1'b1;
            if (j_q == JW'(L-1)) begin
               j_d     = '0;
               state_d = WRITE;
            end else begin
               j_d = j_q + 1'b1;
            end
         end
         WRITE: begin
            busy    = 1'b1;
            mac_clr = 1'b1;
            state_d = last_elem ? DONE : MAC;
            // Walk e fastest, then l, then n.
            if (e_q != EW'(E-1)) begin
               e_d = e_q + 1'b1;
            end else begin
               e_d = '0;
               if (l_q != JW'(L-1)) begin
                  l_d = l_q + 1'b1;
               end else begin
                  l_d = '0;
                  if (n_q != NW'(N-1)) n_d = n_q + 1'b1;
               end
            end
         end
         DONE: begin
            busy      = 1'b1;
            done      = 1'b1;
            out_valid = 1'b1;
            state_d   = WAIT_LOW;
         end
         WAIT_LOW: begin
            // A start still held after done must drop before the next job.
            if (!start) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Input latches, result register file and sticky saturation flag.
   always_comb begin
      a_d     = a_q;
      v_d     = v_q;
      prec_d  = prec_q;
      z_d     = z_q;
      sat_d   = sat_q;
      acc_shr = 64'(acc) >>> FRAC;
      sat_res = sat_fx(acc_shr, DW);
      if (state_q == LOAD) begin
         for (int l = 0; l < L; l++)
            for (int n = 0; n < N; n++)
               for (int j = 0; j < L; j++)
                  a_d[l][n][j] = A_in[((l*N+n)*L+j)*DW +: DW];
         for (int j = 0; j < L; j++)
            for (int n = 0; n < N; n++)
               for (int e = 0; e < E; e++)
                  v_d[j][n][e] = V_in[((j*N+n)*E+e)*DW +: DW];
         prec_d = token_precision;
         sat_d  = 1'b0;
      end
      if (state_q == WRITE) begin
         z_d[l_q][n_q][e_q] = DW'(sat_res.val);
         if (sat_res.ovf) sat_d = 1'b1;
      end
   end

   // Control state, counters, flag and result register file.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         j_q     <= '0;
         e_q     <= '0;
         l_q     <= '0;
         n_q     <= '0;
         sat_q   <= 1'b0;
         z_q     <= '{default: '0};
      end else begin
         state_q <= state_d;
         j_q     <= j_d;
         e_q     <= e_d;
         l_q     <= l_d;
         n_q     <= n_d;
         sat_q   <= sat_d;
         z_q     <= z_d;
      end
   end

   // Operand latches are written in LOAD before they are read.
   always_ff @(posedge clk) begin
      // NOTE: the operand storage has no reset. Every job overwrites it in
      // LOAD before the first MAC, so it needs no reset network.
      a_q    <= a_d;
      v_q    <= v_d;
      prec_q <= prec_d;
   end

   // Flatten the result register file onto the output bus.
   always_comb begin
      Z_out = '0;
      for (int l = 0; l < L; l++)
         for (int n = 0; n < N; n++)
            for (int e = 0; e < E; e++)
               Z_out[((l*N+n)*E+e)*DW +: DW] = z_q[l][n][e];
   end

   assign sat_flag = sat_q;

endmodule

// File: tb/tb_av_seq_engine.sv
// Directed testbench for av_seq_engine with hand-computed expected values.
module tb_av_seq_engine;
   import tva_pkg::*;

   localparam int DW   = 16;
   localparam int FRAC = 8;
   localparam int L    = 8;
   localparam int N    = 1;
   localparam int E    = 8;
   localparam int LAT  = 1 + N*L*E*(L+1);

   logic                  clk = 1'b0;
   logic                  rst_n;
   logic                  start;
   logic [DW*L*N*L-1:0]   A_in;
   logic [DW*L*N*E-1:0]   V_in;
   logic [3:0]            token_precision [0:L-1];
   logic [DW*L*N*E-1:0]   Z_out;
   logic                  out_valid, done, busy, sat_flag;

   int checks = 0;
   int errors = 0;

   logic [15:0] a_m   [L][L];
   logic [15:0] v_m   [L][E];
   logic [15:0] exp_z [L][E];

   always #5 clk = ~clk;

   av_seq_engine #(.DATA_WIDTH(DW), .FRAC(FRAC), .L(L), .N(N), .E(E)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .start           (start),
      .A_in            (A_in),
      .V_in            (V_in),
      .token_precision (token_precision),
      .Z_out           (Z_out),
      .out_valid       (out_valid),
      .done            (done),
      .busy            (busy),
      .sat_flag        (sat_flag)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic pack_inputs();
      for (int l = 0; l < L; l++)
         for (int j = 0; j < L; j++)
            A_in[(l*L+j)*DW +: DW] = a_m[l][j];
      for (int j = 0; j < L; j++)
         for (int e = 0; e < E; e++)
            V_in[(j*E+e)*DW +: DW] = v_m[j][e];
   endtask

   task automatic fill(input logic [15:0] a_val, input logic [15:0] v_val, input logic [15:0] z_val);
      for (int r = 0; r < L; r++) begin
         for (int c = 0; c < L; c++) a_m[r][c] = a_val;
         for (int e = 0; e < E; e++) begin
            v_m[r][e]   = v_val;
            exp_z[r][e] = z_val;
         end
      end
      pack_inputs();
   endtask

   // Identity A with random V; the expected Z equals V.
   task automatic fill_identity();
      for (int r = 0; r < L; r++) begin
         for (int c = 0; c < L; c++) a_m[r][c] = (r == c) ? 16'h0100 : 16'h0000;
         for (int e = 0; e < E; e++) begin
            v_m[r][e]   = 16'($urandom);
            exp_z[r][e] = v_m[r][e];
         end
      end
      pack_inputs();
   endtask

   task automatic check_z(input string tag);
      for (int l = 0; l < L; l++)
         for (int e = 0; e < E; e++)
            check($sformatf("%s_z%0d_%0d", tag, l, e), 32'(Z_out[(l*E+e)*DW +: DW]), 32'(exp_z[l][e]));
   endtask

   // Lower start and give the engine time to return to IDLE.
   task automatic gap();
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(posedge clk);
   endtask

   // mode 0: start held; 1: one-cycle pulse; 2: start toggled and A changed
   // mid-job; 3: reset asserted before edge 100 (returns without waiting).
   task automatic run_job(input string tag, input int mode);
      int lat;
      lat = -1;
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1;
      for (int k = 1; k <= LAT + 50; k++) begin
         @(negedge clk);
         if (mode == 1 && k == 1) start = 1'b0;
         if (mode == 2 && k >= 40 && k < 50) start = ~start;
         if (mode == 2 && k == 45) A_in = '0;
         if (mode == 3 && k == 100) begin
            rst_n = 1'b0;
            lat   = -2;
            break;
         end
         @(posedge clk);
         #1;
         if (done) begin
            lat = k;
            break;
         end
      end
      if (mode != 3) begin
         check({tag, "_latency"}, 32'(lat), 32'(LAT));
         check({tag, "_valid_at_done"}, 32'(out_valid), 32'd1);
         check({tag, "_busy_at_done"}, 32'(busy), 32'd1);
         @(posedge clk);
         #1;
         check({tag, "_done_one_cycle"}, 32'(done), 32'd0);
         check({tag, "_valid_one_cycle"}, 32'(out_valid), 32'd0);
         check({tag, "_busy_after"}, 32'(busy), 32'd0);
      end
   endtask

   initial begin
      int extra;
      rst_n = 1'b0;
      start = 1'b0;
      A_in  = '0;
      V_in  = '0;
      for (int j = 0; j < L; j++) token_precision[j] = PREC_FULL;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_done", 32'(done), 32'd0);
      check("rst_valid", 32'(out_valid), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_sat", 32'(sat_flag), 32'd0);
      check("rst_z_zero", 32'(Z_out == '0), 32'd1);
      rst_n = 1'b1;
      repeat (2) @(posedge clk);

      // Identity A, random V, full precision: Z equals V.
      fill_identity();
      run_job("ident", 0);
      check_z("ident");
      check("ident_sat", 32'(sat_flag), 32'd0);

      // Start held high after done must not retrigger.
      extra = 0;
      for (int c = 0; c < 10; c++) begin
         @(posedge clk);
         #1;
         if (done || out_valid || busy) extra++;
      end
      check("hold_no_retrigger", 32'(extra), 32'd0);

      // One cycle low, then high again: second job runs. A=1/8, V=1.0 gives Z=1.0.
      @(negedge clk);
      start = 1'b0;
      fill(16'h0020, 16'h0100, 16'h0100);
      run_job("eighth", 0);
      check_z("eighth");
      check("eighth_sat", 32'(sat_flag), 32'd0);
      gap();

      // Positive saturation, one-cycle start pulse.
      fill(16'h7FFF, 16'h7FFF, 16'h7FFF);
      run_job("satpos", 1);
      check_z("satpos");
      check("satpos_sat", 32'(sat_flag), 32'd1);
      gap();

      // Negative saturation. Start toggles and A changes mid-job; both are ignored.
      fill(16'h7FFF, 16'h8000, 16'h8000);
      run_job("satneg", 2);
      check_z("satneg");
      check("satneg_sat", 32'(sat_flag), 32'd1);
      gap();

      // Precision masking on key token 0: only column 0 of A is 1.0.
      for (int p = 0; p < 3; p++) begin
         logic [3:0]  code;
         logic [15:0] zv;
         code = (p == 0) ? PREC_8 : (p == 1) ? PREC_4 : 4'd3;
         zv   = (p == 0) ? 16'h1200 : (p == 1) ? 16'h1000 : 16'h12FF;
         fill(16'h0000, 16'h7777, zv);
         for (int l = 0; l < L; l++) a_m[l][0] = 16'h0100;
         for (int e = 0; e < E; e++) v_m[0][e] = 16'h12FF;
         pack_inputs();
         token_precision[0] = code;
         run_job($sformatf("prec%0d", code), 1);
         check_z($sformatf("prec%0d", code));
         check($sformatf("prec%0d_sat", code), 32'(sat_flag), 32'd0);
         gap();
      end
      token_precision[0] = PREC_FULL;

      // Asynchronous reset mid-job clears outputs at once.
      fill(16'h7FFF, 16'h7FFF, 16'h7FFF);
      run_job("rstjob", 3);
      #1;
      check("midrst_done", 32'(done), 32'd0);
      check("midrst_valid", 32'(out_valid), 32'd0);
      check("midrst_busy", 32'(busy), 32'd0);
      check("midrst_sat", 32'(sat_flag), 32'd0);
      check("midrst_z_zero", 32'(Z_out == '0), 32'd1);
      start = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(posedge clk);

      // A fresh job after reset completes normally.
      fill_identity();
      run_job("post_rst", 0);
      check_z("post_rst");
      gap();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
